// File: rtl/evaluador_banderas.sv
// evaluador_banderas: flag status register and branch-condition evaluator.
// Captures the ALU flags (N Z C V in bits 3..0) and evaluates a 4-bit
// condition code against them, with a one-cycle registered result.
// Evaluation looks at the flag value being written this cycle (bypass), so
// a compare followed by a same-cycle branch sees the fresh flags.
// Optional feature: define FLAG_STACK_EN to build the 4-deep flag stack used
// for interrupt entry/exit. Without it, push/pop are ignored and the stack
// status outputs are tied to "empty, no error".
module evaluador_banderas (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] Banderas_ALU,
   input  logic       actualizar,
   input  logic       escribir_directo,
   input  logic [3:0] dato_banderas,
   input  logic       evaluar,
   input  logic [3:0] cond,
   input  logic       push,
   input  logic       pop,
   output logic [3:0] banderas,
   output logic       salto_valido,
   output logic       salto_tomar,
   output logic [2:0] profundidad,
   output logic       pila_llena,
   output logic       pila_vacia,
   output logic       error_pila
);

   logic [3:0] flags_q, flags_d;
   logic       valido_q, valido_d;
   logic       tomar_q, tomar_d;
   logic       pop_ok;
   logic [3:0] dato_pop;

   // Condition table; bits of f are {N, Z, C, V}.
   function automatic logic cumple(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      logic r;
      n  = f[3];
      z  = f[2];
      cy = f[1];
      v  = f[0];
      r  = 1'b0;
      case (c)
         4'h0: r = z;
         4'h1: r = ~z;
         4'h2: r = cy;
         4'h3: r = ~cy;
         4'h4: r = n;
         4'h5: r = ~n;
         4'h6: r = v;
         4'h7: r = ~v;
         4'h8: r = cy & ~z;
         4'h9: r = ~cy | z;
         4'hA: r = (n == v);
         4'hB: r = (n != v);
         4'hC: r = ~z & (n == v);
         4'hD: r = z | (n != v);
         4'hE: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

`ifdef FLAG_STACK_EN
   logic [3:0] pila_q [4];
   logic [2:0] prof_q, prof_d;
   logic       err_q, err_d;
   logic       push_ok;
   logic [1:0] idx_tope;

   // Entry just below the write pointer; only read when occupancy is 1..4.
   assign idx_tope = prof_q[1:0] - 2'd1;
   assign dato_pop = pila_q[idx_tope];

   // Stack legality: simultaneous push/pop, push when full and pop when
   // empty are all rejected and reported.
   always_comb begin
      push_ok = 1'b0;
      pop_ok  = 1'b0;
      err_d   = 1'b0;
      prof_d  = prof_q;
      if (push && pop) begin
         err_d = 1'b1;
      end else if (push) begin
         if (prof_q == 3'd4) begin
            err_d = 1'b1;
         end else begin
            push_ok = 1'b1;
            prof_d  = prof_q + 3'd1;
         end
      end else if (pop) begin
         if (prof_q == 3'd0) begin
            err_d = 1'b1;
         end else begin
            pop_ok = 1'b1;
            prof_d = prof_q - 3'd1;
         end
      end
   end

   // Stack storage and occupancy; a push saves the pre-update flag value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            pila_q[i] <= 4'd0;
         end
         prof_q <= 3'd0;
         err_q  <= 1'b0;
      end else begin
         if (push_ok) begin
            pila_q[prof_q[1:0]] <= flags_q;
         end
         prof_q <= prof_d;
         err_q  <= err_d;
      end
   end

   assign profundidad = prof_q;
   assign pila_llena  = (prof_q == 3'd4);
   assign pila_vacia  = (prof_q == 3'd0);
   assign error_pila  = err_q;
`else
   logic unused_pila;

   assign unused_pila = push ^ pop;
   assign pop_ok      = 1'b0;
   assign dato_pop    = 4'd0;
   assign profundidad = 3'd0;
   assign pila_llena  = 1'b0;
   assign pila_vacia  = 1'b1;
   assign error_pila  = 1'b0;
`endif

   // Flag next state: restore from stack beats software write beats ALU.
   always_comb begin
      flags_d = flags_q;
      if (pop_ok) begin
         flags_d = dato_pop;
      end else if (escribir_directo) begin
         flags_d = dato_banderas;
      end else if (actualizar) begin
         flags_d = Banderas_ALU;
      end
   end

   // Evaluation against the bypassed next-state flags.
   always_comb begin
      valido_d = evaluar;
      tomar_d  = evaluar & cumple(cond, flags_d);
   end

   // Flag register and the one-cycle evaluation result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q  <= 4'd0;
         valido_q <= 1'b0;
         tomar_q  <= 1'b0;
      end else begin
         flags_q  <= flags_d;
         valido_q <= valido_d;
         tomar_q  <= tomar_d;
      end
   end

   assign banderas     = flags_q;
   assign salto_valido = valido_q;
   assign salto_tomar  = tomar_q;

endmodule

// File: tb/tb_evaluador_banderas.sv
// Self-checking bench for evaluador_banderas against a queue-based model.
// Compile with FLAG_STACK_EN defined to exercise the flag stack.
module tb_evaluador_banderas;

   logic       clk;
   logic       rst_n;
   logic [3:0] Banderas_ALU;
   logic       actualizar;
   logic       escribir_directo;
   logic [3:0] dato_banderas;
   logic       evaluar;
   logic [3:0] cond;
   logic       push;
   logic       pop;
   logic [3:0] banderas;
   logic       salto_valido;
   logic       salto_tomar;
   logic [2:0] profundidad;
   logic       pila_llena;
   logic       pila_vacia;
   logic       error_pila;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [3:0] m_flags;
   logic [3:0] m_stack [$];
   logic       m_valido;
   logic       m_tomar;
   logic       m_err;

   evaluador_banderas dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .Banderas_ALU     (Banderas_ALU),
      .actualizar       (actualizar),
      .escribir_directo (escribir_directo),
      .dato_banderas    (dato_banderas),
      .evaluar          (evaluar),
      .cond             (cond),
      .push             (push),
      .pop              (pop),
      .banderas         (banderas),
      .salto_valido     (salto_valido),
      .salto_tomar      (salto_tomar),
      .profundidad      (profundidad),
      .pila_llena       (pila_llena),
      .pila_vacia       (pila_vacia),
      .error_pila       (error_pila)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Codes come in predicate/negation pairs: odd code = even code inverted.
   function automatic bit modelo_cond(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;                  // equal
         3'd1: base = cy;                 // carry set
         3'd2: base = n;                  // negative
         3'd3: base = v;                  // overflow
         3'd4: base = cy && !z;           // unsigned higher
         3'd5: base = (n == v);           // signed >=
         3'd6: base = !z && (n == v);     // signed >
         default: base = 1'b1;            // always
      endcase
      return base ^ c[0];
   endfunction

   task automatic clear_inputs();
      Banderas_ALU = 4'd0; actualizar = 1'b0; escribir_directo = 1'b0;
      dato_banderas = 4'd0; evaluar = 1'b0; cond = 4'd0; push = 1'b0; pop = 1'b0;
   endtask

   task automatic model_reset();
      m_flags = 4'd0; m_stack.delete(); m_valido = 1'b0; m_tomar = 1'b0; m_err = 1'b0;
   endtask

   // Advance one clock, updating the model from the inputs currently driven.
   task automatic tick();
      logic [3:0] nf;
      bit restored;
      nf = m_flags;
      restored = 1'b0;
      m_err = 1'b0;
`ifdef FLAG_STACK_EN
      if (push && pop) m_err = 1'b1;
      else if (push) begin
         if (m_stack.size() == 4) m_err = 1'b1;
         else m_stack.push_back(m_flags);
      end else if (pop) begin
         if (m_stack.size() == 0) m_err = 1'b1;
         else begin
            nf = m_stack.pop_back();
            restored = 1'b1;
         end
      end
`endif
      if (!restored) begin
         if (escribir_directo) nf = dato_banderas;
         else if (actualizar) nf = Banderas_ALU;
      end
      m_valido = evaluar;
      m_tomar  = evaluar && modelo_cond(cond, nf);
      m_flags  = nf;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      model_reset();
      #12;
      checks++; if (banderas !== 4'd0) begin errors++; $display("FAIL reset_banderas got %h want 0", banderas); end
      checks++; if (salto_valido !== 1'b0 || salto_tomar !== 1'b0) begin errors++; $display("FAIL reset_salto got %b%b want 00", salto_valido, salto_tomar); end
      checks++; if (profundidad !== 3'd0) begin errors++; $display("FAIL reset_profundidad got %0d want 0", profundidad); end
      checks++; if (pila_vacia !== 1'b1 || pila_llena !== 1'b0) begin errors++; $display("FAIL reset_vacia_llena got %b%b want 10", pila_vacia, pila_llena); end
      checks++; if (error_pila !== 1'b0) begin errors++; $display("FAIL reset_error_pila got %b want 0", error_pila); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_bypass_eq();
      do_reset();
      actualizar = 1'b1; Banderas_ALU = 4'b0100; evaluar = 1'b1; cond = 4'h0;
      tick();
      clear_inputs();
      checks++; if (banderas !== 4'b0100) begin errors++; $display("FAIL bypass_banderas got %b want 0100", banderas); end
      checks++; if (salto_valido !== 1'b1) begin errors++; $display("FAIL bypass_valido got %b want 1", salto_valido); end
      checks++; if (salto_tomar !== 1'b1) begin errors++; $display("FAIL bypass_tomar got %b want 1", salto_tomar); end
      tick();
      checks++; if (salto_valido !== 1'b0 || salto_tomar !== 1'b0) begin errors++; $display("FAIL bypass_pulse_end got %b%b want 00", salto_valido, salto_tomar); end
   endtask

   task automatic test_signed_codes();
      logic [3:0] codes [4];
      logic       want [4];
      codes = '{4'hA, 4'hB, 4'hC, 4'hD};
      want  = '{1'b0, 1'b1, 1'b0, 1'b1};
      escribir_directo = 1'b1; dato_banderas = 4'b1000;
      tick();
      clear_inputs();
      for (int i = 0; i < 4; i++) begin
         evaluar = 1'b1; cond = codes[i];
         tick();
         checks++; if (salto_valido !== 1'b1 || salto_tomar !== want[i] || salto_tomar !== m_tomar) begin
            errors++; $display("FAIL signed_code_%h got v=%b t=%b want v=1 t=%b", codes[i], salto_valido, salto_tomar, want[i]);
         end
      end
      clear_inputs();
   endtask

   task automatic test_priority();
      escribir_directo = 1'b1; dato_banderas = 4'b1001;
      actualizar = 1'b1; Banderas_ALU = 4'b0010;
      tick();
      clear_inputs();
      checks++; if (banderas !== 4'b1001) begin errors++; $display("FAIL priority_write got %b want 1001", banderas); end
      actualizar = 1'b1; Banderas_ALU = 4'b0010;
      tick();
      clear_inputs();
      checks++; if (banderas !== 4'b0010) begin errors++; $display("FAIL priority_update got %b want 0010", banderas); end
      tick();
      checks++; if (banderas !== 4'b0010) begin errors++; $display("FAIL priority_hold got %b want 0010", banderas); end
   endtask

`ifdef FLAG_STACK_EN
   task automatic test_stack_fill_drain();
      logic [3:0] v [6];
      logic [2:0] dep_want [5];
      logic [3:0] pop_want [5];
      v        = '{4'h9, 4'h3, 4'hC, 4'h5, 4'hE, 4'h7};
      dep_want = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      pop_want = '{4'h5, 4'hC, 4'h3, 4'h9, 4'h9};
      do_reset();
      escribir_directo = 1'b1; dato_banderas = v[0];
      tick();
      for (int i = 0; i < 5; i++) begin
         push = 1'b1; escribir_directo = 1'b1; dato_banderas = v[i+1];
         tick();
         checks++; if (profundidad !== dep_want[i] || error_pila !== (i == 4)) begin
            errors++; $display("FAIL push_%0d got depth=%0d err=%b want depth=%0d err=%b", i, profundidad, error_pila, dep_want[i], (i == 4));
         end
      end
      clear_inputs();
      checks++; if (pila_llena !== 1'b1) begin errors++; $display("FAIL stack_full got %b want 1", pila_llena); end
      for (int i = 0; i < 5; i++) begin
         pop = 1'b1;
         tick();
         checks++; if (banderas !== pop_want[i] || banderas !== m_flags || error_pila !== (i == 4)) begin
            errors++; $display("FAIL pop_%0d got flags=%h err=%b want flags=%h err=%b", i, banderas, error_pila, pop_want[i], (i == 4));
         end
      end
      clear_inputs();
      checks++; if (pila_vacia !== 1'b1 || profundidad !== 3'd0) begin errors++; $display("FAIL stack_empty got vacia=%b depth=%0d want 1 0", pila_vacia, profundidad); end
   endtask

   task automatic test_push_pop_together();
      do_reset();
      push = 1'b1;
      tick();
      tick();
      push = 1'b1; pop = 1'b1; escribir_directo = 1'b1; dato_banderas = 4'hB;
      tick();
      clear_inputs();
      checks++; if (profundidad !== 3'd2 || error_pila !== 1'b1) begin errors++; $display("FAIL push_pop_same got depth=%0d err=%b want 2 1", profundidad, error_pila); end
      checks++; if (banderas !== 4'hB) begin errors++; $display("FAIL push_pop_write got %h want b", banderas); end
      tick();
      checks++; if (error_pila !== 1'b0) begin errors++; $display("FAIL push_pop_pulse got %b want 0", error_pila); end
   endtask
`else
   task automatic test_stack_ignored();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         push = (i % 2 == 0); pop = (i % 3 != 0);
         escribir_directo = 1'b1; dato_banderas = 4'(i + 3);
         tick();
         checks++; if (profundidad !== 3'd0 || error_pila !== 1'b0 || pila_vacia !== 1'b1 || pila_llena !== 1'b0 || banderas !== 4'(i + 3)) begin
            errors++; $display("FAIL stack_ignored_%0d got depth=%0d err=%b vacia=%b llena=%b flags=%h want 0 0 1 0 %h",
                               i, profundidad, error_pila, pila_vacia, pila_llena, banderas, 4'(i + 3));
         end
      end
      clear_inputs();
   endtask
`endif

   task automatic test_random();
      int bad;
      bad = 0;
      for (int n = 0; n < 400; n++) begin
         Banderas_ALU     = 4'($urandom_range(0, 15));
         actualizar       = 1'($urandom_range(0, 1));
         escribir_directo = ($urandom_range(0, 3) == 0);
         dato_banderas    = 4'($urandom_range(0, 15));
         evaluar          = ($urandom_range(0, 3) != 0);
         cond             = 4'($urandom_range(0, 15));
         push             = ($urandom_range(0, 3) == 0);
         pop              = ($urandom_range(0, 3) == 0);
         tick();
         checks++;
         if (banderas !== m_flags || salto_valido !== m_valido || salto_tomar !== m_tomar ||
             error_pila !== m_err || profundidad !== 3'(m_stack.size()) ||
             pila_llena !== (m_stack.size() == 4) || pila_vacia !== (m_stack.size() == 0)) begin
            errors++;
            bad++;
            if (bad <= 10)
               $display("FAIL random_%0d got f=%h v=%b t=%b e=%b d=%0d ll=%b va=%b want f=%h v=%b t=%b e=%b d=%0d",
                        n, banderas, salto_valido, salto_tomar, error_pila, profundidad, pila_llena, pila_vacia,
                        m_flags, m_valido, m_tomar, m_err, m_stack.size());
         end
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
`ifdef FLAG_STACK_EN
      for (int i = 0; i < 3; i++) begin
         push = 1'b1; escribir_directo = 1'b1; dato_banderas = 4'(i + 1);
         tick();
      end
      clear_inputs();
      checks++; if (profundidad !== 3'd3) begin errors++; $display("FAIL midreset_setup got depth=%0d want 3", profundidad); end
`endif
      escribir_directo = 1'b1; dato_banderas = 4'hF; evaluar = 1'b1; cond = 4'hE;
      tick();
      checks++; if (salto_valido !== 1'b1 || salto_tomar !== 1'b1) begin errors++; $display("FAIL midreset_pre got %b%b want 11", salto_valido, salto_tomar); end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if (banderas !== 4'd0 || salto_valido !== 1'b0 || salto_tomar !== 1'b0 || profundidad !== 3'd0 ||
                    pila_vacia !== 1'b1 || pila_llena !== 1'b0 || error_pila !== 1'b0) begin
         errors++; $display("FAIL midreset_async got f=%h v=%b t=%b d=%0d va=%b ll=%b e=%b want reset values",
                            banderas, salto_valido, salto_tomar, profundidad, pila_vacia, pila_llena, error_pila);
      end
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b1;
      tick();
      checks++; if (salto_valido !== 1'b0 || profundidad !== 3'd0 || banderas !== 4'd0) begin
         errors++; $display("FAIL midreset_after got v=%b d=%0d f=%h want 0 0 0", salto_valido, profundidad, banderas);
      end
`ifdef FLAG_STACK_EN
      pop = 1'b1;
      tick();
      clear_inputs();
      checks++; if (error_pila !== 1'b1 || banderas !== 4'd0) begin errors++; $display("FAIL midreset_stack_cleared got e=%b f=%h want 1 0", error_pila, banderas); end
`endif
   endtask

   initial begin
      test_reset();
      test_bypass_eq();
      test_signed_codes();
      test_priority();
`ifdef FLAG_STACK_EN
      test_stack_fill_drain();
      test_push_pop_together();
`else
      test_stack_ignored();
`endif
      do_reset();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/evaluador_banderas.md
# evaluador_banderas

Flag status register and branch-condition evaluator that consumes the 4-bit `Banderas_ALU` vector produced by the ALU flag logic. It captures flags on ALU writeback, evaluates a 4-bit condition code against them for the control unit, and optionally saves and restores flags on a 4-deep stack for interrupt entry and exit. It sits between the ALU datapath and the sequencer/branch unit.

## Interface
- No parameters. Stack depth is fixed at 4.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Banderas_ALU` in 4: flags from ALU, [3]=N, [2]=Z, [1]=C, [0]=V.
- `actualizar` in 1: latch `Banderas_ALU` into the flag register.
- `escribir_directo` in 1: latch `dato_banderas` into the flag register (software write).
- `dato_banderas` in 4: direct-write value, same bit order as `Banderas_ALU`.
- `evaluar` in 1: request a condition evaluation.
- `cond` in 4: condition code to evaluate.
- `push` in 1: save the flag register onto the stack.
- `pop` in 1: restore the flag register from the stack top.
- `banderas` out 4: current flag register.
- `salto_valido` out 1: evaluation result valid (1-cycle pulse).
- `salto_tomar` out 1: condition true; meaningful only while `salto_valido`=1, otherwise 0.
- `profundidad` out 3: stack occupancy, 0..4.
- `pila_llena` out 1: `profundidad`==4.
- `pila_vacia` out 1: `profundidad`==0.
- `error_pila` out 1: 1-cycle pulse on an illegal stack operation.

## Operation
- Flag register next-state priority: valid pop > `escribir_directo` > `actualizar` > hold.
- Condition codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
- Evaluation uses the flag register's next-state value for that cycle, i.e. the value after a same-cycle update, direct write or pop (bypass).
- Stack operations:
  - Push saves the current registered value, i.e. the value before any same-cycle update. The entry is written and `profundidad` increments.
  - Valid pop loads the top entry into the flag register and decrements `profundidad`.
- Push while full: stack unchanged; `error_pila` pulses.
- Pop while empty: stack and register unaffected by the pop. Lower-priority writes still apply. `error_pila` pulses.
- Push and pop asserted together: both ignored, stack unchanged, `error_pila` pulses. Other writes still apply.
- `profundidad` never wraps; it saturates by rejecting the operation.

## Timing
- Reset values (asynchronous, while `rst_n`=0): `banderas`=0000, `salto_valido`=0, `salto_tomar`=0, `profundidad`=0, `pila_vacia`=1, `pila_llena`=0, `error_pila`=0, all stack entries 0.
- Flag write latency: one cycle. Write sampled at edge k; visible on `banderas` after edge k.
- Evaluation latency: one cycle. `evaluar` sampled at edge k makes `salto_valido`/`salto_tomar` high for exactly the cycle after edge k.
- Back-to-back `evaluar` every cycle gives one result per cycle, in order. There is no backpressure.
- `error_pila`, `profundidad` and the full/empty flags are registered and update at the same edge as the stack operation.
- Reset asserted mid-operation discards any pending result and all stack contents. There is no partial state after release.

## Configuration
- `FLAG_STACK_EN` defined: stack implemented as described.
- `FLAG_STACK_EN` undefined:
  - Ports remain; `push` and `pop` are ignored.
  - `profundidad`=0, `pila_vacia`=1, `pila_llena`=0, `error_pila`=0 at all times.
  - Flag register priority becomes `escribir_directo` > `actualizar` > hold.

## Test plan
- Reset release, then `actualizar` with `Banderas_ALU`=0100 and `evaluar` with `cond`=0 in the same cycle -> next cycle `banderas`=0100, `salto_valido`=1, `salto_tomar`=1 (bypass EQ).
- Flags N=1, V=0 registered; evaluate codes A, B, C, D on consecutive cycles -> `salto_tomar` = 0, 1, 0, 1 on consecutive cycles, each with `salto_valido`=1.
- Same-cycle `escribir_directo` with `dato_banderas`=1001 and `actualizar` with `Banderas_ALU`=0010 -> `banderas`=1001.
- (`FLAG_STACK_EN`) Push five distinct flag values -> `profundidad` 1,2,3,4,4; `pila_llena`=1; `error_pila` pulses on the fifth push. Then five pops -> flags restored in LIFO order; `error_pila` pulses on the fifth pop; `pila_vacia`=1.
- (`FLAG_STACK_EN`) `push` and `pop` together at `profundidad`=2 -> `profundidad` stays 2; `error_pila` pulses for one cycle.
- Assert `rst_n`=0 mid-sequence with `profundidad`=3 and `evaluar` pending -> all outputs return to reset values immediately, with no `salto_valido` pulse after release.
